shift_arbiter: RTL and testbench

- Shares one 16-bit barrel `shifter` instance (ops: SRA/SRL/ROL/SLL, 4-bit count) between two requesters, e.g. the execute-stage ALU path and a multi-cycle address/immediate-formatting unit.
- Arbitrates the requests, registers the granted operands, runs the shift, registers the result, and signals completion with a one-cycle done pulse per requester.
- Sits beside the ALU in the execute stage.

---
 rtl/shift_arbiter_if.sv | 35 +++
 rtl/shift_arbiter.sv | 135 +++++++++++++
 tb/tb_shift_arbiter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_arbiter_if.sv
// Requester-facing bundle for the shared shifter: two request channels plus
// the shared result, completion pulses and status.
interface shift_arbiter_if;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned OP_W   = 2;

  logic              req0;
  logic [DATA_W-1:0] in0;
  logic [CNT_W-1:0]  cnt0;
  logic [OP_W-1:0]   op0;
  logic              req1;
  logic [DATA_W-1:0] in1;
  logic [CNT_W-1:0]  cnt1;
  logic [OP_W-1:0]   op1;
  logic              done0;
  logic              done1;
  logic [DATA_W-1:0] out;
  logic              busy;
  logic              gnt;

  // Requester side drives requests and operands
  modport master (
    output req0, in0, cnt0, op0,
    output req1, in1, cnt1, op1,
    input  done0, done1, out, busy, gnt
  );

  // Arbiter side consumes requests and returns results
  modport slave (
    input  req0, in0, cnt0, op0,
    input  req1, in1, cnt1, op1,
    output done0, done1, out, busy, gnt
  );
endinterface

// File: rtl/shift_arbiter.sv
// Two-requester arbiter around a single 16-bit barrel shifter.
// Flow per operation: IDLE (grant + latch operands) -> SHIFT (capture result)
// -> DONE (one-cycle done pulse to the granted requester) -> IDLE.

// Combinational barrel shifter: 00 SRA, 01 SRL, 10 ROL, 11 SLL.
module shifter (
  input  logic [15:0] data,
  input  logic [3:0]  cnt,
  input  logic [1:0]  op,
  output logic [15:0] result_c
);
  localparam int unsigned DATA_W = 16;

  // Select the shift flavour; cnt=0 passes data through for every op
  always_comb begin
    result_c = data;
    case (op)
      2'b00:   result_c = DATA_W'($signed(data) >>> cnt);
      2'b01:   result_c = data >> cnt;
      2'b10:   result_c = (data << cnt) | (data >> (5'(DATA_W) - 5'(cnt)));
      default: result_c = data << cnt;
    endcase
  end
endmodule

module shift_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  shift_arbiter_if.slave bus
);
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned OP_W   = 2;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  cnt;
    logic [OP_W-1:0]   op;
  } operand_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  operand_t          opnd;
  operand_t          win_opnd_c;
  logic              ptr;
  logic              grant_c;
  logic              win_c;
  logic              grant_id;
  logic [DATA_W-1:0] shift_c;
  logic [DATA_W-1:0] result;
  logic [1:0]        done_vec;
  logic              busy_reg;

  // Shifter sees only the latched operands, never the live request inputs
  shifter u_shifter (
    .data     (opnd.data),
    .cnt      (opnd.cnt),
    .op       (opnd.op),
    .result_c (shift_c)
  );

  // Arbitration: grants only in IDLE; pointer decides ties when RR_EN is set
  always_comb begin
    grant_c = 1'b0;
    win_c   = 1'b0;
    if (state == IDLE) begin
      grant_c = bus.req0 | bus.req1;
      if (bus.req0 && bus.req1) begin
        win_c = RR_EN ? ptr : 1'b0;
      end else begin
        win_c = bus.req1;
      end
    end
    win_opnd_c = win_c ? operand_t'{bus.in1, bus.cnt1, bus.op1}
                       : operand_t'{bus.in0, bus.cnt0, bus.op0};
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_c) state_next = SHIFT;
      SHIFT:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand latch, pointer, result capture and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      opnd     <= '0;
      ptr      <= 1'b0;
      grant_id <= 1'b0;
      result   <= '0;
      done_vec <= 2'b00;
      busy_reg <= 1'b0;
    end else begin
      busy_reg <= (state_next != IDLE);
      done_vec <= 2'b00;
      if (grant_c) begin
        opnd     <= win_opnd_c;
        grant_id <= win_c;
        ptr      <= ~win_c;
      end
      if (state == SHIFT) begin
        result   <= shift_c;
        done_vec <= grant_id ? 2'b10 : 2'b01;
      end
    end
  end

  assign bus.out   = result;
  assign bus.done0 = done_vec[0];
  assign bus.done1 = done_vec[1];
  assign bus.busy  = busy_reg;
  assign bus.gnt   = grant_id;
endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: one round-robin and one fixed-priority instance,
// directed scenarios followed by randomized rounds against a reference model.
module tb_shift_arbiter;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  shift_arbiter_if bus_rr ();
  shift_arbiter_if bus_fp ();

  // Stimulus indexed [dut][requester]; dut 0 = round-robin, 1 = fixed priority
  logic        req_s [2][2];
  logic [15:0] in_s  [2][2];
  logic [3:0]  cnt_s [2][2];
  logic [1:0]  op_s  [2][2];

  logic        done0_w [2];
  logic        done1_w [2];
  logic [15:0] out_w   [2];
  logic        busy_w  [2];
  logic        gnt_w   [2];

  assign bus_rr.req0 = req_s[0][0];
  assign bus_rr.in0  = in_s[0][0];
  assign bus_rr.cnt0 = cnt_s[0][0];
  assign bus_rr.op0  = op_s[0][0];
  assign bus_rr.req1 = req_s[0][1];
  assign bus_rr.in1  = in_s[0][1];
  assign bus_rr.cnt1 = cnt_s[0][1];
  assign bus_rr.op1  = op_s[0][1];
  assign bus_fp.req0 = req_s[1][0];
  assign bus_fp.in0  = in_s[1][0];
  assign bus_fp.cnt0 = cnt_s[1][0];
  assign bus_fp.op0  = op_s[1][0];
  assign bus_fp.req1 = req_s[1][1];
  assign bus_fp.in1  = in_s[1][1];
  assign bus_fp.cnt1 = cnt_s[1][1];
  assign bus_fp.op1  = op_s[1][1];

  assign done0_w[0] = bus_rr.done0;
  assign done1_w[0] = bus_rr.done1;
  assign out_w[0]   = bus_rr.out;
  assign busy_w[0]  = bus_rr.busy;
  assign gnt_w[0]   = bus_rr.gnt;
  assign done0_w[1] = bus_fp.done0;
  assign done1_w[1] = bus_fp.done1;
  assign out_w[1]   = bus_fp.out;
  assign busy_w[1]  = bus_fp.busy;
  assign gnt_w[1]   = bus_fp.gnt;

  shift_arbiter #(.RR_EN(1'b1)) dut_rr (.clk(clk), .rst(rst), .bus(bus_rr.slave));
  shift_arbiter #(.RR_EN(1'b0)) dut_fp (.clk(clk), .rst(rst), .bus(bus_fp.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 2; r++) begin
        req_s[d][r] = 1'b0;
        in_s[d][r]  = 16'h0000;
        cnt_s[d][r] = 4'd0;
        op_s[d][r]  = 2'b00;
      end
    end
  endtask

  // Reference shift: bit-at-a-time steps and plain arithmetic
  function automatic logic [15:0] ref_shift(input logic [15:0] a, input logic [3:0] c,
                                            input logic [1:0] o);
    logic [15:0] x;
    int          n;
    x = a;
    n = int'(c);
    case (o)
      2'b00: for (int i = 0; i < n; i++) x = {x[15], x[15:1]};
      2'b01: x = 16'(32'(a) / (32'd1 << n));
      2'b10: for (int i = 0; i < n; i++) x = {x[14:0], x[15]};
      default: x = 16'(32'(a) * (32'd1 << n));
    endcase
    return x;
  endfunction

  // One uncontended request on dut d from requester r, full handshake
  task automatic single_op(input int d, input int r, input logic [15:0] a,
                           input logic [3:0] c, input logic [1:0] o,
                           input logic [15:0] exp, input string tag);
    req_s[d][r] = 1'b1;
    in_s[d][r]  = a;
    cnt_s[d][r] = c;
    op_s[d][r]  = o;
    tick();
    check_bit({tag, "_gnt"}, gnt_w[d], 1'(r));
    check_bit({tag, "_busy_shift"}, busy_w[d], 1'b1);
    check_bit({tag, "_nodone_shift"}, done0_w[d] | done1_w[d], 1'b0);
    tick();
    check_word({tag, "_out"}, out_w[d], exp);
    check_bit({tag, "_done"}, (r == 0) ? done0_w[d] : done1_w[d], 1'b1);
    check_bit({tag, "_other_done"}, (r == 0) ? done1_w[d] : done0_w[d], 1'b0);
    check_bit({tag, "_busy_done"}, busy_w[d], 1'b1);
    req_s[d][r] = 1'b0;
    tick();
    check_bit({tag, "_busy_idle"}, busy_w[d], 1'b0);
    check_bit({tag, "_done_drop"}, done0_w[d] | done1_w[d], 1'b0);
    check_word({tag, "_out_hold"}, out_w[d], exp);
  endtask

  initial begin
    int          win [2];
    logic [15:0] exp_out [2];
    logic        ptr_m [2];
    int          pick;
    logic        both;

    tests = 0;
    fails = 0;
    rst   = 1'b1;
    clear_inputs();

    // Reset state
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      check_word($sformatf("rst_out_d%0d", d), out_w[d], 16'h0000);
      check_bit($sformatf("rst_busy_d%0d", d), busy_w[d], 1'b0);
      check_bit($sformatf("rst_gnt_d%0d", d), gnt_w[d], 1'b0);
      check_bit($sformatf("rst_done_d%0d", d), done0_w[d] | done1_w[d], 1'b0);
    end
    rst = 1'b0;
    tick();
    check_bit("idle_no_req", busy_w[0], 1'b0);

    // First op: SRA of 8001 by 1
    single_op(0, 0, 16'h8001, 4'd1, 2'b00, 16'hC000, "sra1");

    // Op sweep on requester 1
    single_op(0, 1, 16'h8001, 4'd4, 2'b01, 16'h0800, "srl4");
    single_op(0, 1, 16'h8001, 4'd4, 2'b10, 16'h0018, "rol4");
    single_op(0, 1, 16'h8001, 4'd4, 2'b11, 16'h0010, "sll4");
    single_op(0, 1, 16'h8001, 4'd4, 2'b00, 16'hF800, "sra4");
    for (int o = 0; o < 4; o++) begin
      single_op(0, 1, 16'h8001, 4'd0, 2'(o), 16'h8001, $sformatf("cnt0_op%0d", o));
    end
    single_op(0, 0, 16'hFFFF, 4'd15, 2'b01, 16'h0001, "srl15");

    // Contention with both requests held, fresh pointers
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_s[d][0] = 1'b1; in_s[d][0] = 16'h00F0; cnt_s[d][0] = 4'd4; op_s[d][0] = 2'b11;
      req_s[d][1] = 1'b1; in_s[d][1] = 16'h00F0; cnt_s[d][1] = 4'd4; op_s[d][1] = 2'b01;
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      check_bit($sformatf("rr_gnt%0d", k), gnt_w[0], 1'(k % 2));
      check_bit($sformatf("fp_gnt%0d", k), gnt_w[1], 1'b0);
      tick();
      check_bit($sformatf("rr_done0_%0d", k), done0_w[0], 1'(k % 2 == 0));
      check_bit($sformatf("rr_done1_%0d", k), done1_w[0], 1'(k % 2 == 1));
      check_word($sformatf("rr_out%0d", k), out_w[0], (k % 2 == 1) ? 16'h000F : 16'h0F00);
      check_bit($sformatf("fp_done0_%0d", k), done0_w[1], 1'b1);
      check_bit($sformatf("fp_done1_%0d", k), done1_w[1], 1'b0);
      check_word($sformatf("fp_out%0d", k), out_w[1], 16'h0F00);
      tick();
      check_bit($sformatf("rr_pulse_end%0d", k), done0_w[0] | done1_w[0], 1'b0);
    end
    req_s[0][0] = 1'b0;
    req_s[0][1] = 1'b0;
    req_s[1][0] = 1'b0;
    tick();
    check_bit("fp_gnt_after_drop", gnt_w[1], 1'b1);
    tick();
    check_bit("fp_done1_after_drop", done1_w[1], 1'b1);
    check_word("fp_out_after_drop", out_w[1], 16'h000F);
    req_s[1][1] = 1'b0;
    tick();
    check_bit("fp_idle_after_drop", busy_w[1], 1'b0);
    check_bit("rr_idle_after_drop", busy_w[0], 1'b0);

    // Operand changes after the grant edge must not affect the result
    req_s[0][0] = 1'b1; in_s[0][0] = 16'h00FF; cnt_s[0][0] = 4'd8; op_s[0][0] = 2'b11;
    tick();
    in_s[0][0]  = 16'hFFFF;
    cnt_s[0][0] = 4'd1;
    tick();
    check_word("latched_operand_out", out_w[0], 16'hFF00);
    check_bit("latched_operand_done", done0_w[0], 1'b1);
    req_s[0][0] = 1'b0;
    tick();

    // Reset during SHIFT aborts the operation
    req_s[0][0] = 1'b1; in_s[0][0] = 16'h0F0F; cnt_s[0][0] = 4'd0; op_s[0][0] = 2'b10;
    tick();
    check_bit("abort_busy_before", busy_w[0], 1'b1);
    rst = 1'b1;
    req_s[0][0] = 1'b0;
    tick();
    check_bit("abort_busy", busy_w[0], 1'b0);
    check_word("abort_out", out_w[0], 16'h0000);
    check_bit("abort_done", done0_w[0] | done1_w[0], 1'b0);
    rst = 1'b0;
    tick();
    check_bit("abort_no_late_done", done0_w[0] | done1_w[0], 1'b0);
    check_bit("abort_still_idle", busy_w[0], 1'b0);
    single_op(0, 0, 16'h1234, 4'd4, 2'b10, 16'h2341, "after_abort");

    // Randomized rounds against the reference model
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ptr_m[0] = 1'b0;
    ptr_m[1] = 1'b0;
    for (int n = 0; n < 150; n++) begin
      for (int d = 0; d < 2; d++) begin
        for (int r = 0; r < 2; r++) begin
          if (!req_s[d][r] && $urandom_range(0, 1) == 1) begin
            req_s[d][r] = 1'b1;
            in_s[d][r]  = 16'($urandom);
            cnt_s[d][r] = 4'($urandom);
            op_s[d][r]  = 2'($urandom);
          end
        end
        if (!req_s[d][0] && !req_s[d][1]) begin
          pick = int'($urandom_range(0, 1));
          req_s[d][pick] = 1'b1;
          in_s[d][pick]  = 16'($urandom);
          cnt_s[d][pick] = 4'($urandom);
          op_s[d][pick]  = 2'($urandom);
        end
        both = req_s[d][0] & req_s[d][1];
        if (both) win[d] = (d == 0) ? int'(ptr_m[d]) : 0;
        else      win[d] = req_s[d][1] ? 1 : 0;
        ptr_m[d]   = (win[d] == 0);
        exp_out[d] = ref_shift(in_s[d][win[d]], cnt_s[d][win[d]], op_s[d][win[d]]);
      end
      tick();
      for (int d = 0; d < 2; d++) begin
        check_bit($sformatf("rnd%0d_d%0d_gnt", n, d), gnt_w[d], 1'(win[d]));
        check_bit($sformatf("rnd%0d_d%0d_busy", n, d), busy_w[d], 1'b1);
        in_s[d][win[d]]  = 16'($urandom);
        cnt_s[d][win[d]] = 4'($urandom);
      end
      tick();
      for (int d = 0; d < 2; d++) begin
        check_word($sformatf("rnd%0d_d%0d_out", n, d), out_w[d], exp_out[d]);
        check_bit($sformatf("rnd%0d_d%0d_done0", n, d), done0_w[d], 1'(win[d] == 0));
        check_bit($sformatf("rnd%0d_d%0d_done1", n, d), done1_w[d], 1'(win[d] == 1));
        req_s[d][win[d]] = 1'b0;
      end
      tick();
      for (int d = 0; d < 2; d++) begin
        check_bit($sformatf("rnd%0d_d%0d_idle", n, d), busy_w[d], 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
